// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory-channel responder: FSM encoding, header layout,
// response codes and the request/response lengths.
package mem_responder_pkg;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ACCESS    = 2'd1;
  localparam logic [1:0] S_READ_WAIT = 2'd2;
  localparam logic [1:0] S_RESPOND   = 2'd3;

  localparam int unsigned HDR_WRITE_BIT = 0;
  localparam int unsigned HDR_MASK_LSB  = 4;
  localparam int unsigned HDR_MASK_MSB  = 7;

  localparam logic [7:0] ACK_BYTE = 8'h01;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  localparam logic [4:0] LEN_READ       = 5'd5;
  localparam logic [4:0] LEN_WRITE      = 5'd9;
  localparam logic [4:0] LEN_READ_RESP  = 5'd4;
  localparam logic [4:0] LEN_SHORT_RESP = 5'd1;

endpackage

// File: rtl/mem_responder_ram.sv
// Word-addressed 32-bit RAM with per-byte write enables and a registered read port.
module mem_responder_ram #(
  parameter int unsigned ADDR_BIT = 10
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [3:0]          be_i,
  input  logic [ADDR_BIT-1:0] addr_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o
);

  logic [31:0] mem_q [(1 << ADDR_BIT)];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Responder end of the memory channel serving word reads/writes from an internal RAM.
// MEM_RESPONDER_WRITE_ACK_EN: when defined, valid writes are acknowledged; otherwise posted.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned MESSAGE_BIT = 72,
  parameter int unsigned ADDR_BIT    = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   readable,
  input  logic [MESSAGE_BIT-1:0] read_data,
  input  logic [4:0]             read_length,
  output logic                   read_flag,
  input  logic                   writable,
  output logic                   write_flag,
  output logic [MESSAGE_BIT-1:0] write_data,
  output logic [4:0]             write_length,
  output logic                   busy
);

  logic [1:0]             state_q, state_d;
  logic [MESSAGE_BIT-1:0] req_q, req_d;
  logic [4:0]             len_q, len_d;
  logic [MESSAGE_BIT-1:0] resp_data_q, resp_data_d;
  logic [4:0]             resp_len_q, resp_len_d;

  logic [7:0]  hdr;
  logic        is_write, valid_rd, valid_wr, ram_we;
  logic [31:0] ram_rdata;
  logic        unused_bits;

  assign hdr      = req_q[7:0];
  assign is_write = hdr[HDR_WRITE_BIT];
  assign valid_rd = !is_write && (len_q == LEN_READ);
  assign valid_wr = is_write && (len_q == LEN_WRITE);
  assign ram_we   = (state_q == S_ACCESS) && valid_wr;

  // Byte-offset and upper address bits are ignored so addresses wrap over the RAM.
  assign unused_bits = ^{req_q[39:ADDR_BIT+10], req_q[9:8], hdr[3:1]};

  mem_responder_ram #(
    .ADDR_BIT (ADDR_BIT)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .be_i    (hdr[HDR_MASK_MSB:HDR_MASK_LSB]),
    .addr_i  (req_q[10 +: ADDR_BIT]),
    .wdata_i (req_q[71:40]),
    .rdata_o (ram_rdata)
  );

  assign read_flag    = RST && (state_q == S_IDLE) && readable;
  assign write_flag   = (state_q == S_RESPOND) && writable;
  assign write_data   = resp_data_q;
  assign write_length = resp_len_q;
  assign busy         = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    len_d       = len_q;
    resp_data_d = resp_data_q;
    resp_len_d  = resp_len_q;
    case (state_q)
      S_IDLE: begin
        if (readable) begin
          req_d   = read_data;
          len_d   = read_length;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (valid_rd) begin
          state_d = S_READ_WAIT;
        end else if (valid_wr) begin
`ifdef MEM_RESPONDER_WRITE_ACK_EN
          resp_data_d      = '0;
          resp_data_d[7:0] = ACK_BYTE;
          resp_len_d       = LEN_SHORT_RESP;
          state_d          = S_RESPOND;
`else
          state_d = S_IDLE;
`endif
        end else begin
          resp_data_d      = '0;
          resp_data_d[7:0] = ERR_BYTE;
          resp_len_d       = LEN_SHORT_RESP;
          state_d          = S_RESPOND;
        end
      end
      S_READ_WAIT: begin
        resp_data_d       = '0;
        resp_data_d[31:0] = ram_rdata;
        resp_len_d        = LEN_READ_RESP;
        state_d           = S_RESPOND;
      end
      S_RESPOND: begin
        if (writable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      len_q       <= '0;
      resp_data_q <= '0;
      resp_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      len_q       <= len_d;
      resp_data_q <= resp_data_d;
      resp_len_q  <= resp_len_d;
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MESSAGE_BIT, default 72, message payload width (bytes = MESSAGE_BIT/8).
REQ-002 SHALL have parameter ADDR_BIT, default 10, log2 of internal RAM depth in 32-bit words.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port readable  input  1  request message available at channel head.
REQ-006 SHALL have port read_data  input  MESSAGE_BIT  head request payload, valid while readable.
REQ-007 SHALL have port read_length  input  5  head request length in bytes.
REQ-008 SHALL have port read_flag  output  1  one-cycle pop of head request.
REQ-009 SHALL have port writable  input  1  channel accepts one response message.
REQ-010 SHALL have port write_flag  output  1  one-cycle push of response.
REQ-011 SHALL have port write_data  output  MESSAGE_BIT  response payload.
REQ-012 SHALL have port write_length  output  5  response length in bytes.
REQ-013 SHALL have port busy  output  1  high in every state except S_IDLE.

Function
REQ-014 SHALL act as the responder end of the memory channel and serve word requests from an internal 2^ADDR_BIT x 32 RAM with 1-cycle synchronous read.
REQ-015 SHALL decode payload byte i as bits [8i+7:8i]; byte0 header: bit0 = 1 write / 0 read, bits 7:4 byte-write mask; bytes1-4 address, little-endian; bytes5-8 write data, little-endian.
REQ-016 SHALL use address bits [ADDR_BIT+1:2] as word index; address bits [1:0] and bits above ADDR_BIT+1 ignored (wrap-around).
REQ-017 SHALL assert read_flag combinationally when state is S_IDLE and readable=1, capturing read_data and read_length into registers on that edge.
REQ-018 SHALL implement states S_IDLE, S_ACCESS, S_READ_WAIT, S_RESPOND: S_IDLE->S_ACCESS on pop; S_ACCESS->S_READ_WAIT on valid read, ->S_RESPOND on write or error; S_READ_WAIT->S_RESPOND; S_RESPOND->S_IDLE on edge where write_flag=1.
REQ-019 SHALL treat a request as valid only if read length is 5 or write length is 9; anything else is an error, no RAM access.
REQ-020 SHALL, in S_ACCESS for a valid write, update only RAM bytes whose mask bit is 1 (mask bit k -> data byte k); mask 0 performs no update yet still responds.
REQ-021 SHALL respond to a read with length 4, bytes0-3 = RAM word, little-endian.
REQ-022 SHALL respond to an error with length 1, byte0 = 0xEE.
REQ-023 SHALL hold write_data/write_length stable throughout S_RESPOND and assert write_flag for exactly one cycle, the first S_RESPOND cycle with writable=1.
REQ-024 SHALL drive unused write_data bytes to zero.
REQ-025 SHALL give read latency of pop edge + 3 cycles to write_flag when writable stays high.
REQ-026 SHALL process one request at a time; readable during a non-idle state is ignored until return to S_IDLE.

Reset
REQ-027 SHALL, with RST=0 at a clock edge, enter S_IDLE and set read_flag=0, write_flag=0, write_data=0, write_length=0, busy=0.
REQ-028 SHALL, on reset mid-operation, discard the in-flight request without sending a response; a RAM write already committed stays; RAM contents are never cleared by reset.

Configuration
REQ-029 SHALL honour macro MEM_RESPONDER_WRITE_ACK_EN: defined -> valid write answered with length 1, byte0 = 0x01; undefined -> valid writes are posted, no response, S_ACCESS->S_IDLE directly.

Structure
REQ-030 SHALL place state encoding, header bit positions, ACK (0x01) and ERR (0xEE) constants, and request lengths (5, 9) in a shared package.
REQ-031 SHALL isolate the RAM in one sub-module, mem_responder_ram (byte-masked write, synchronous read).

Verification
REQ-032 SHALL cover write addr 0x00000010 data 0xDEADBEEF mask 0xF, then read 0x10 -> read response length 4, bytes EF BE AD DE.
REQ-033 SHALL cover masked write 0x11223344 mask 0x5 over 0xDEADBEEF at 0x10, then read -> 0xDE22BE44.
REQ-034 SHALL cover read request with length 3 -> single response length 1, byte0 0xEE; RAM unchanged.
REQ-035 SHALL cover writable held low 10 cycles during S_RESPOND -> write_flag exactly once, on the first cycle writable=1; data stable throughout.
REQ-036 SHALL cover ADDR_BIT=10, write to 0x00001004, read 0x00000004 -> same word (wrap); with WRITE_ACK_EN defined, write gives length 1 byte 0x01.
REQ-037 SHALL cover RST=0 asserted during S_READ_WAIT -> no response, busy=0 next cycle, next request served normally.
